mem_arbiter_wb: RTL and testbench
=================================

Name: mem_arbiter_wb

Overview:
Shares the single cacheline adapter between the icache (read-only) and the dcache (read/write). Replaces fixed-priority sharing with round-robin read arbitration and a small posted write-back buffer. Dcache write-backs are acknowledged as soon as they are buffered and drained to memory when no read is waiting. Reads that hit a buffered line are forwarded from the buffer without a memory access.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cacheline width in bits
OFFSET_W, 5, line-offset bits ignored in address compare
WB_DEPTH, 2, write-buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
icache_read  in  1  icache line read request, held until icache_resp
icache_address  in  ADDR_W  icache request address
icache_rdata  out  LINE_W  line returned to icache
icache_resp  out  1  one-cycle completion pulse
dcache_read  in  1  dcache line read request, held until dcache_resp
dcache_write  in  1  dcache write-back request, held until dcache_resp
dcache_address  in  ADDR_W  dcache request address
dcache_wdata  in  LINE_W  write-back line
dcache_rdata  out  LINE_W  line returned to dcache
dcache_resp  out  1  one-cycle completion pulse
mem_read  out  1  adapter read request
mem_write  out  1  adapter write request
mem_address  out  ADDR_W  adapter address
mem_wdata  out  LINE_W  adapter write line
mem_rdata  in  LINE_W  adapter read line
mem_resp  in  1  adapter completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; buffer empty (head=tail=0, count=0); last_grant=DCACHE, so icache wins the first tie. All outputs are 0, including rdata buses.
- Clock and reset are fixed as stated: one clock, clk; asynchronous, active-low reset, rst_n.
- Line match: addresses compared on [ADDR_W-1:OFFSET_W] only.
- States: IDLE, RD_I, RD_D, DRAIN, FWD, RESP.
- IDLE decision, in priority order:
  1. Buffer full and any request pending -> DRAIN (oldest entry).
  2. Pending read whose line matches a valid buffer entry -> FWD. On multiple matches, the youngest entry wins. If both caches hit, round-robin picks one.
  3. Both reads pending -> grant the cache that is not last_grant. Only one read pending -> grant it. Go to RD_I or RD_D and update last_grant.
  4. dcache_write, buffer not full -> push {address, wdata} at tail. If the same line is already buffered, overwrite that entry instead and do not push. Go to RESP with dcache_resp.
  5. No request and buffer not empty -> DRAIN.
  6. Otherwise stay in IDLE.
- RD_I / RD_D: mem_read=1; mem_address = granted cache address. Stay until mem_resp. In the mem_resp cycle, pass mem_resp and mem_rdata combinationally to the granted cache's resp/rdata, then go to IDLE.
- DRAIN: mem_write=1; mem_address/mem_wdata = head entry. On mem_resp, pop the head, send no cache resp, and go to IDLE.
- FWD: one cycle. Drive the matched entry's data on the requester's rdata, then go to RESP. The requester's resp is pulsed in RESP with rdata held.
- RESP: exactly one cycle of the selected resp; rdata is held. Then go to IDLE.
- Requesters drop their request in the cycle after resp, so IDLE never re-serves a completed request.
- Read latency: hit = 2 cycles after IDLE sampling; miss = memory latency + 1. Write ack = 1 cycle after IDLE sampling, when the buffer is not full.
- Coherence: a read never reaches memory while a matching line sits in the buffer. The FWD check is mandatory.
- Simultaneous dcache_read and dcache_write are illegal; the read takes precedence, and an assertion is required.
- Reset mid-transaction aborts: outputs drop immediately and buffered lines are lost.
- count increments and decrements without overflow; pointers wrap modulo WB_DEPTH.

Decomposition:
- Package mem_arb_pkg: arb_state_e enum; grant_e {GNT_ICACHE, GNT_DCACHE}; wb_entry_t struct {addr, data, valid}; LINE_W/ADDR_W defaults.
- Sub-module wb_buffer: circular buffer with push, pop, same-line overwrite, parallel line-match lookup returning the youngest hit index, full/empty/count.
- The arbiter FSM lives in mem_arbiter_wb.

Test Plan:
- Icache read 0x0000_0040 alone, memory returns line A after 5 cycles -> mem_read with addr 0x40; icache_resp one pulse carrying A; dcache_resp stays 0.
- Icache and dcache reads held together for 3 rounds -> grants go icache, dcache, icache; no starvation.
- Dcache write 0x100 with data B -> dcache_resp 1 cycle after IDLE with no memory access; drain follows with mem_write, address 0x100, data B.
- Write 0x100 (B), then dcache read 0x11C before the drain -> FWD returns B; mem_read never asserted.
- Fill buffer (0x200, 0x300), then icache read 0x400 -> 0x200 is drained first, then the read is served; count never exceeds 2.
- Deassert rst_n during RD_D -> mem_read drops asynchronously; after release, state is IDLE and the buffer is empty.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the icache/dcache memory arbiter with
// posted write-back buffer.
//   arb_state_e : arbiter FSM states
//   grant_e     : which cache owns the current read / response
//   wb_entry_t  : layout of one write-back buffer entry at default widths
package mem_arb_pkg;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_LINE_W   = 256;
   localparam int DEF_OFFSET_W = 5;
   localparam int DEF_WB_DEPTH = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_I  = 3'd1,
      ST_RD_D  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FWD   = 3'd4,
      ST_RESP  = 3'd5
   } arb_state_e;

   typedef enum logic {
      GNT_ICACHE = 1'b0,
      GNT_DCACHE = 1'b1
   } grant_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_LINE_W-1:0] data;
      logic                  valid;
   } wb_entry_t;

endpackage

// File: rtl/mem_arbiter_wb_wb_buffer.sv
// Circular posted write-back buffer.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data : write a line; overwrites a buffered entry of the
//                             same line, otherwise pushes at tail (if not full)
//   pop                     : retire the head entry (ignored when empty)
//   lkp_i_tag, lkp_d_tag    : line tags looked up in parallel
//   hit_*, hit_*_idx        : lookup hit and index of the youngest matching entry
//   rd_idx, rd_data         : random read of an entry's data (forwarding)
//   head_addr, head_data    : oldest entry, used for draining
//   full, empty, count      : occupancy
module wb_buffer
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int LINE_W   = DEF_LINE_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int WB_DEPTH = DEF_WB_DEPTH,
   localparam int PTR_W   = $clog2(WB_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [LINE_W-1:0]        wr_data,
   input  logic                     pop,
   input  logic [ADDR_W-1:OFFSET_W] lkp_i_tag,
   input  logic [ADDR_W-1:OFFSET_W] lkp_d_tag,
   output logic                     hit_i,
   output logic [PTR_W-1:0]         hit_i_idx,
   output logic                     hit_d,
   output logic [PTR_W-1:0]         hit_d_idx,
   input  logic [PTR_W-1:0]         rd_idx,
   output logic [LINE_W-1:0]        rd_data,
   output logic [ADDR_W-1:0]        head_addr,
   output logic [LINE_W-1:0]        head_data,
   output logic                     full,
   output logic                     empty,
   output logic [PTR_W:0]           count
);

   logic [ADDR_W-1:0]   addr_q [WB_DEPTH];
   logic [LINE_W-1:0]   data_q [WB_DEPTH];
   logic [WB_DEPTH-1:0] valid_q;
   logic [PTR_W-1:0]    head_q;
   logic [PTR_W-1:0]    tail_q;
   logic [PTR_W:0]      count_q;

   logic                wr_hit;
   logic [PTR_W-1:0]    wr_idx;
   logic [PTR_W-1:0]    wr_slot;
   logic                push;
   logic                pop_ok;

   // Walk entries from oldest to youngest so the last match seen is the
   // youngest one.
   function automatic logic [PTR_W:0] youngest_hit(input logic [ADDR_W-1:OFFSET_W] tag);
      logic [PTR_W:0]   res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (valid_q[idx] && (addr_q[idx][ADDR_W-1:OFFSET_W] == tag))
            res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      {hit_i, hit_i_idx} = youngest_hit(lkp_i_tag);
      {hit_d, hit_d_idx} = youngest_hit(lkp_d_tag);
      {wr_hit, wr_idx}   = youngest_hit(wr_addr[ADDR_W-1:OFFSET_W]);
   end

   assign full      = (count_q == (PTR_W+1)'(WB_DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign push      = wr_en && !wr_hit && !full;
   assign pop_ok    = pop && !empty;
   assign wr_slot   = wr_hit ? wr_idx : tail_q;
   assign rd_data   = data_q[rd_idx];
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (pop_ok) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (push && !pop_ok)
            count_q <= count_q + 1'b1;
         else if (pop_ok && !push)
            count_q <= count_q - 1'b1;
      end
   end

   // Entry payload carries no reset; valid_q alone decides what is live.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_hit || !full)) begin
         addr_q[wr_slot] <= wr_addr;
         data_q[wr_slot] <= wr_data;
      end
   end

endmodule

// File: rtl/mem_arbiter_wb.sv
// Arbiter sharing one cacheline memory adapter between the icache (reads)
// and the dcache (reads and write-backs). Reads are granted round-robin,
// write-backs are posted into wb_buffer and acknowledged immediately, and
// reads hitting a buffered line are forwarded without touching memory.
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   icache_read/address, icache_rdata/resp  : icache line read channel
//   dcache_read/write/address/wdata,
//   dcache_rdata/resp                       : dcache line read / write-back channel
//   mem_read/write/address/wdata,
//   mem_rdata/resp                          : cacheline adapter channel
module mem_arbiter_wb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int LINE_W   = DEF_LINE_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int WB_DEPTH = DEF_WB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_read,
   input  logic [ADDR_W-1:0] icache_address,
   output logic [LINE_W-1:0] icache_rdata,
   output logic              icache_resp,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [ADDR_W-1:0] dcache_address,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              dcache_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int PTR_W = $clog2(WB_DEPTH);

   arb_state_e       state_q, state_d;
   grant_e           last_grant_q, last_grant_d;
   grant_e           sel_q, sel_d;
   logic [PTR_W-1:0] fwd_idx_q, fwd_idx_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic             line_load;

   logic             wb_wr_en;
   logic             wb_pop;
   logic             hit_i, hit_d;
   logic [PTR_W-1:0] hit_i_idx, hit_d_idx;
   logic [LINE_W-1:0] wb_rd_data;
   logic [ADDR_W-1:0] wb_head_addr;
   logic [LINE_W-1:0] wb_head_data;
   logic             wb_full, wb_empty;
   logic [PTR_W:0]   wb_count;

   logic             any_req;
   logic             i_hit, d_hit;

   wb_buffer #(
      .ADDR_W   (ADDR_W),
      .LINE_W   (LINE_W),
      .OFFSET_W (OFFSET_W),
      .WB_DEPTH (WB_DEPTH)
   ) u_wb (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wb_wr_en),
      .wr_addr   (dcache_address),
      .wr_data   (dcache_wdata),
      .pop       (wb_pop),
      .lkp_i_tag (icache_address[ADDR_W-1:OFFSET_W]),
      .lkp_d_tag (dcache_address[ADDR_W-1:OFFSET_W]),
      .hit_i     (hit_i),
      .hit_i_idx (hit_i_idx),
      .hit_d     (hit_d),
      .hit_d_idx (hit_d_idx),
      .rd_idx    (fwd_idx_q),
      .rd_data   (wb_rd_data),
      .head_addr (wb_head_addr),
      .head_data (wb_head_data),
      .full      (wb_full),
      .empty     (wb_empty),
      .count     (wb_count)
   );

   assign any_req = icache_read || dcache_read || dcache_write;
   assign i_hit   = icache_read && hit_i;
   assign d_hit   = dcache_read && hit_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GNT_DCACHE;
         sel_q        <= GNT_ICACHE;
         fwd_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         fwd_idx_q    <= fwd_idx_d;
      end
   end

   // Response line is only observed in RESP, after being loaded.
   always_ff @(posedge clk) begin
      if (line_load)
         line_q <= line_d;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      fwd_idx_d    = fwd_idx_q;
      line_load    = 1'b0;
      line_d       = '0;
      wb_wr_en     = 1'b0;
      wb_pop       = 1'b0;
      icache_rdata = '0;
      icache_resp  = 1'b0;
      dcache_rdata = '0;
      dcache_resp  = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_address  = '0;
      mem_wdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (wb_full && any_req) begin
               // Free a slot first so a pending write can always be posted.
               state_d = ST_DRAIN;
            end else if (i_hit || d_hit) begin
               // Forwarding comes before any memory read so a stale line is
               // never fetched while a newer copy sits in the buffer.
               if (i_hit && (!d_hit || last_grant_q == GNT_DCACHE)) begin
                  sel_d     = GNT_ICACHE;
                  fwd_idx_d = hit_i_idx;
               end else begin
                  sel_d     = GNT_DCACHE;
                  fwd_idx_d = hit_d_idx;
               end
               last_grant_d = sel_d;
               state_d      = ST_FWD;
            end else if (icache_read || dcache_read) begin
               if (icache_read && (!dcache_read || last_grant_q == GNT_DCACHE)) begin
                  last_grant_d = GNT_ICACHE;
                  state_d      = ST_RD_I;
               end else begin
                  last_grant_d = GNT_DCACHE;
                  state_d      = ST_RD_D;
               end
            end else if (dcache_write) begin
               wb_wr_en  = 1'b1;
               sel_d     = GNT_DCACHE;
               line_load = 1'b1;
               state_d   = ST_RESP;
            end else if (!wb_empty) begin
               state_d = ST_DRAIN;
            end
         end
         ST_RD_I: begin
            mem_read    = 1'b1;
            mem_address = icache_address;
            icache_resp = mem_resp;
            if (mem_resp) begin
               icache_rdata = mem_rdata;
               state_d      = ST_IDLE;
            end
         end
         ST_RD_D: begin
            mem_read    = 1'b1;
            mem_address = dcache_address;
            dcache_resp = mem_resp;
            if (mem_resp) begin
               dcache_rdata = mem_rdata;
               state_d      = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            mem_write   = 1'b1;
            mem_address = wb_head_addr;
            mem_wdata   = wb_head_data;
            if (mem_resp) begin
               wb_pop  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FWD: begin
            if (sel_q == GNT_ICACHE)
               icache_rdata = wb_rd_data;
            else
               dcache_rdata = wb_rd_data;
            line_load = 1'b1;
            line_d    = wb_rd_data;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            if (sel_q == GNT_ICACHE) begin
               icache_resp  = 1'b1;
               icache_rdata = line_q;
            end else begin
               dcache_resp  = 1'b1;
               dcache_rdata = line_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The dcache must never raise read and write-back together; if it does,
   // the read is served first.
   a_dcache_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(dcache_read && dcache_write));

   a_wb_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      wb_count <= (PTR_W+1)'(WB_DEPTH));

endmodule

// File: tb/tb_mem_arbiter_wb.sv
module tb_mem_arbiter_wb;

   logic         clk;
   logic         rst_n;
   logic         icache_read;
   logic [31:0]  icache_address;
   logic [255:0] icache_rdata;
   logic         icache_resp;
   logic         dcache_read;
   logic         dcache_write;
   logic [31:0]  dcache_address;
   logic [255:0] dcache_wdata;
   logic [255:0] dcache_rdata;
   logic         dcache_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;

   int errors = 0;
   int checks = 0;

   localparam logic [255:0] LINE_A  = {8{32'hAAAA_0040}};
   localparam logic [255:0] LINE_B  = {8{32'hBBBB_0100}};
   localparam logic [255:0] LINE_B2 = {8{32'hB2B2_0100}};
   localparam logic [255:0] LINE_C  = {8{32'hCCCC_0200}};
   localparam logic [255:0] LINE_D  = {8{32'hDDDD_0300}};
   localparam logic [255:0] LINE_E  = {8{32'hEEEE_0700}};
   localparam logic [255:0] LINE_R1 = {8{32'h1111_1000}};
   localparam logic [255:0] LINE_R2 = {8{32'h2222_2000}};
   localparam logic [255:0] LINE_R3 = {8{32'h3333_1040}};
   localparam logic [255:0] LINE_M4 = {8{32'h4444_0400}};
   localparam logic [255:0] LINE_M7 = {8{32'h7777_0700}};

   mem_arbiter_wb dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_rdata   (icache_rdata),
      .icache_resp    (icache_resp),
      .dcache_read    (dcache_read),
      .dcache_write   (dcache_write),
      .dcache_address (dcache_address),
      .dcache_wdata   (dcache_wdata),
      .dcache_rdata   (dcache_rdata),
      .dcache_resp    (dcache_resp),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One memory read: the next edge must grant it, then memory answers after
   // lat cycles in RD and the granted cache gets the line combinationally.
   task automatic rd_round(input string tag, input logic exp_i, input logic [31:0] exp_addr,
                           input logic [255:0] line, input int lat);
      step();
      @(negedge clk);
      check_bit({tag, "_mem_read"}, mem_read, 1'b1);
      check_word({tag, "_mem_addr"}, mem_address, exp_addr);
      for (int k = 1; k < lat; k++) begin
         step();
         @(negedge clk);
         check_bit({tag, "_no_early_resp"}, icache_resp | dcache_resp, 1'b0);
      end
      step();
      mem_resp  = 1'b1;
      mem_rdata = line;
      @(negedge clk);
      check_bit({tag, "_i_resp"}, icache_resp, exp_i);
      check_bit({tag, "_d_resp"}, dcache_resp, !exp_i);
      check_line({tag, "_rdata"}, exp_i ? icache_rdata : dcache_rdata, line);
      step();
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   // Memory accepts the head write-back after one cycle in DRAIN.
   task automatic drain_round(input string tag, input logic [31:0] exp_addr, input logic [255:0] exp_data);
      step();
      @(negedge clk);
      check_bit({tag, "_mem_write"}, mem_write, 1'b1);
      check_bit({tag, "_no_mem_read"}, mem_read, 1'b0);
      check_word({tag, "_addr"}, mem_address, exp_addr);
      check_line({tag, "_wdata"}, mem_wdata, exp_data);
      step();
      mem_resp = 1'b1;
      @(negedge clk);
      check_bit({tag, "_no_cache_resp"}, icache_resp | dcache_resp, 1'b0);
      step();
      mem_resp = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      icache_read    = 1'b0;
      icache_address = '0;
      dcache_read    = 1'b0;
      dcache_write   = 1'b0;
      dcache_address = '0;
      dcache_wdata   = '0;
      mem_rdata      = '0;
      mem_resp       = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("rst_mem_read", mem_read, 1'b0);
      check_bit("rst_mem_write", mem_write, 1'b0);
      check_word("rst_mem_addr", mem_address, 32'h0);
      check_bit("rst_i_resp", icache_resp, 1'b0);
      check_bit("rst_d_resp", dcache_resp, 1'b0);
      check_line("rst_i_rdata", icache_rdata, '0);
      check_line("rst_d_rdata", dcache_rdata, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Round robin: both reads held, new addresses after each completion
      icache_read    = 1'b1;
      icache_address = 32'h0000_1000;
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_2000;
      rd_round("rr1", 1'b1, 32'h0000_1000, LINE_R1, 2);
      icache_address = 32'h0000_1040;
      rd_round("rr2", 1'b0, 32'h0000_2000, LINE_R2, 2);
      dcache_address = 32'h0000_2040;
      rd_round("rr3", 1'b1, 32'h0000_1040, LINE_R3, 2);
      icache_read = 1'b0;
      dcache_read = 1'b0;

      // Lone icache read, memory latency 5
      icache_read    = 1'b1;
      icache_address = 32'h0000_0040;
      rd_round("iread", 1'b1, 32'h0000_0040, LINE_A, 5);
      icache_read = 1'b0;
      @(negedge clk);
      check_bit("iread_resp_single", icache_resp, 1'b0);
      check_bit("iread_mem_idle", mem_read, 1'b0);

      // Posted write-back then drain
      dcache_write   = 1'b1;
      dcache_address = 32'h0000_0100;
      dcache_wdata   = LINE_B;
      step();
      @(negedge clk);
      check_bit("wr_ack", dcache_resp, 1'b1);
      check_bit("wr_no_mem", mem_read | mem_write, 1'b0);
      step();
      dcache_write = 1'b0;
      @(negedge clk);
      check_bit("wr_ack_single", dcache_resp, 1'b0);
      drain_round("wr_drain", 32'h0000_0100, LINE_B);
      @(negedge clk);
      check_bit("wr_drain_done", mem_write, 1'b0);
      step();
      @(negedge clk);
      check_bit("wr_empty_after_pop", mem_write, 1'b0);

      // Forwarding: read of the same line before it drains
      dcache_write   = 1'b1;
      dcache_address = 32'h0000_0100;
      dcache_wdata   = LINE_B2;
      step();
      @(negedge clk);
      check_bit("fwd_wr_ack", dcache_resp, 1'b1);
      step();
      dcache_write   = 1'b0;
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_011C;
      step();
      @(negedge clk);
      check_line("fwd_cycle_rdata", dcache_rdata, LINE_B2);
      check_bit("fwd_cycle_no_resp", dcache_resp, 1'b0);
      check_bit("fwd_cycle_no_mem_read", mem_read, 1'b0);
      step();
      @(negedge clk);
      check_bit("fwd_resp", dcache_resp, 1'b1);
      check_line("fwd_resp_rdata", dcache_rdata, LINE_B2);
      check_bit("fwd_resp_no_mem_read", mem_read, 1'b0);
      step();
      dcache_read = 1'b0;
      @(negedge clk);
      check_bit("fwd_resp_single", dcache_resp, 1'b0);
      drain_round("fwd_drain", 32'h0000_0100, LINE_B2);

      // Fill the buffer, then a read must wait for the oldest drain
      dcache_write   = 1'b1;
      dcache_address = 32'h0000_0200;
      dcache_wdata   = LINE_C;
      step();
      @(negedge clk);
      check_bit("fill_ack0", dcache_resp, 1'b1);
      step();
      dcache_address = 32'h0000_0300;
      dcache_wdata   = LINE_D;
      step();
      @(negedge clk);
      check_bit("fill_ack1", dcache_resp, 1'b1);
      check_bit("fill_ack1_no_mem", mem_read | mem_write, 1'b0);
      step();
      dcache_write   = 1'b0;
      icache_read    = 1'b1;
      icache_address = 32'h0000_0400;
      drain_round("full_drain", 32'h0000_0200, LINE_C);
      rd_round("full_rd", 1'b1, 32'h0000_0400, LINE_M4, 2);
      icache_read = 1'b0;
      drain_round("full_drain2", 32'h0000_0300, LINE_D);

      // Reset in the middle of a dcache memory read
      dcache_write   = 1'b1;
      dcache_address = 32'h0000_0700;
      dcache_wdata   = LINE_E;
      step();
      @(negedge clk);
      check_bit("rst_pre_wr_ack", dcache_resp, 1'b1);
      step();
      dcache_write   = 1'b0;
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_0600;
      step();
      @(negedge clk);
      check_bit("rdd_mem_read", mem_read, 1'b1);
      check_word("rdd_mem_addr", mem_address, 32'h0000_0600);
      #2 rst_n = 1'b0;
      #1;
      check_bit("async_rst_mem_read", mem_read, 1'b0);
      check_word("async_rst_mem_addr", mem_address, 32'h0);
      dcache_read = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         check_bit("post_rst_idle", mem_read | mem_write, 1'b0);
      end
      // The buffered 0x700 line was lost, so this read must go to memory.
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_0700;
      rd_round("post_rst_rd", 1'b0, 32'h0000_0700, LINE_M7, 1);
      dcache_read = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
